// File: rtl/light_package.sv
// Shared lamp colour and phase encodings for the N-approach traffic light controller.
package light_package;

  typedef enum logic [1:0] {
    C_RED    = 2'b00,
    C_YELLOW = 2'b01,
    C_GREEN  = 2'b10
  } colors;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } tlc_phase_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_light_controller_n_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping, 'last' itself checked last.
module tlc_rr_pick #(
  parameter int N_DIR = 3,
  parameter int DW    = (N_DIR > 1) ? $clog2(N_DIR) : 1
) (
  input  logic [N_DIR-1:0] req,
  input  logic [DW-1:0]    last,
  output logic             valid,
  output logic [DW-1:0]    grant
);

  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int i = 1; i <= N_DIR; i++) begin
      if (!valid && req[(int'(last) + i) % N_DIR]) begin
        valid = 1'b1;
        grant = DW'((int'(last) + i) % N_DIR);
      end
    end
  end

endmodule

// File: rtl/traffic_light_controller_n.sv
// N-approach traffic light controller: one green at a time, gap/max-green timing, round-robin service.
// Optional emergency preemption is compiled in with `define TLC_PREEMPT_EN.
module traffic_light_controller_n
  import light_package::*;
#(
  parameter int N_DIR   = 3,
  parameter int GAP_CYC = 5,
  parameter int MAX_CYC = 10,
  parameter int YEL_CYC = 2,
  parameter int RED_CYC = 1,
  localparam int DW = (N_DIR > 1) ? $clog2(N_DIR) : 1,
  localparam int CW = $clog2(imax(imax(GAP_CYC, MAX_CYC), imax(YEL_CYC, RED_CYC)) + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_DIR-1:0]       sensor,
  output logic [N_DIR-1:0][1:0]  light,
  output tlc_phase_e             phase,
  output logic [DW-1:0]          active_dir
`ifdef TLC_PREEMPT_EN
  ,
  input  logic                   preempt,
  input  logic [DW-1:0]          preempt_dir
`endif
);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] MAX_LAST = CW'(MAX_CYC - 1);
  localparam logic [CW-1:0] YEL_LAST = CW'(YEL_CYC - 1);
  localparam logic [CW-1:0] RED_LAST = CW'(RED_CYC - 1);
  localparam logic [DW-1:0] DIR_LAST = DW'(N_DIR - 1);

  tlc_phase_e       phase_d;
  logic [DW-1:0]    dir_d;
  logic [CW-1:0]    phase_ctr, phase_ctr_d;
  logic [CW-1:0]    gap_ctr, gap_ctr_d;
  logic [CW-1:0]    max_ctr, max_ctr_d;
  logic [N_DIR-1:0] own_mask;
  logic             gap_inc, max_inc;
  logic             rr_valid;
  logic [DW-1:0]    rr_grant;
  logic             pre_valid;
  logic [DW-1:0]    pre_dir;

`ifdef TLC_PREEMPT_EN
  // Out-of-range preempt_dir is treated as no request at all.
  assign pre_valid = preempt && (int'(preempt_dir) < N_DIR);
  assign pre_dir   = preempt_dir;
`else
  assign pre_valid = 1'b0;
  assign pre_dir   = '0;
`endif

  tlc_rr_pick #(.N_DIR(N_DIR), .DW(DW)) u_rr_pick (
    .req   (sensor),
    .last  (active_dir),
    .valid (rr_valid),
    .grant (rr_grant)
  );

  assign own_mask = N_DIR'(1) << active_dir;
  // Gap timer latches on once own traffic first drops; max timer once any conflict is seen.
  assign gap_inc  = !sensor[active_dir] || (gap_ctr != '0);
  assign max_inc  = (|(sensor & ~own_mask)) || (max_ctr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= ALLRED;
      active_dir <= DIR_LAST;
      phase_ctr  <= '0;
      gap_ctr    <= '0;
      max_ctr    <= '0;
    end else begin
      phase      <= phase_d;
      active_dir <= dir_d;
      phase_ctr  <= phase_ctr_d;
      gap_ctr    <= gap_ctr_d;
      max_ctr    <= max_ctr_d;
    end
  end

  always_comb begin
    phase_d     = phase;
    dir_d       = active_dir;
    phase_ctr_d = phase_ctr;
    gap_ctr_d   = gap_ctr;
    max_ctr_d   = max_ctr;
    case (phase)
      ALLRED: begin
        gap_ctr_d = '0;
        max_ctr_d = '0;
        if (phase_ctr < RED_LAST) begin
          phase_ctr_d = phase_ctr + ONE;
        end else if (pre_valid) begin
          phase_d     = GREEN;
          dir_d       = pre_dir;
          phase_ctr_d = '0;
        end else if (rr_valid) begin
          phase_d     = GREEN;
          dir_d       = rr_grant;
          phase_ctr_d = '0;
        end
      end
      GREEN: begin
        phase_ctr_d = '0;
        if (pre_valid && (pre_dir != active_dir)) begin
          phase_d   = YELLOW;
          gap_ctr_d = '0;
          max_ctr_d = '0;
        end else if (pre_valid) begin
          gap_ctr_d = '0;
          max_ctr_d = '0;
        end else if ((gap_inc && gap_ctr == GAP_LAST) || (max_inc && max_ctr == MAX_LAST)) begin
          phase_d   = YELLOW;
          gap_ctr_d = '0;
          max_ctr_d = '0;
        end else begin
          if (gap_inc) gap_ctr_d = gap_ctr + ONE;
          if (max_inc) max_ctr_d = max_ctr + ONE;
        end
      end
      YELLOW: begin
        gap_ctr_d = '0;
        max_ctr_d = '0;
        if (phase_ctr >= YEL_LAST) begin
          phase_d     = ALLRED;
          phase_ctr_d = '0;
        end else begin
          phase_ctr_d = phase_ctr + ONE;
        end
      end
      default: begin
        phase_d     = ALLRED;
        phase_ctr_d = '0;
        gap_ctr_d   = '0;
        max_ctr_d   = '0;
      end
    endcase
  end

  for (genvar d = 0; d < N_DIR; d++) begin : g_lamp
    assign light[d] = (active_dir != DW'(d)) ? C_RED    :
                      (phase == GREEN)       ? C_GREEN  :
                      (phase == YELLOW)      ? C_YELLOW : C_RED;
  end

endmodule
